// File: rtl/intr_vec_fetch.sv
// Vectored interrupt controller: prioritises four level interrupt lines, handshakes with the CPU,
// and fetches the handler address from a 4-entry table in data memory. Optional mask: IVF_MASK_EN.
module intr_vec_fetch #(
  parameter logic [31:0] VEC_BASE = 32'h00000020
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [3:0]  irq,
  input  logic        ie,
  output logic        intr_req,
  input  logic        intr_ack,
  input  logic        eret,
  output logic [31:0] vec_pc,
  output logic        vec_valid,
  output logic [1:0]  cause,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  input  logic [31:0] mem_din
`ifdef IVF_MASK_EN
  ,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ADDR = 3'd2,
    WAIT = 3'd3,
    CAPT = 3'd4,
    SERV = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  eff_irq;
  logic [1:0]  pick_idx;
  logic        take_irq;

`ifdef IVF_MASK_EN
  logic [3:0]  mask;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mask <= 4'hF;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  assign eff_irq = irq & mask;
`else
  assign eff_irq = irq;
`endif

  // Lowest-index asserted line wins; scanning downwards leaves the lowest set bit.
  always_comb begin
    pick_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eff_irq[i]) begin
        pick_idx = 2'(i);
      end
    end
  end

  assign take_irq = ie && (eff_irq != 4'd0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take_irq) state_nx = REQ;
      REQ:  if (intr_ack) state_nx = ADDR;
      ADDR: if (mem_gnt)  state_nx = WAIT;
      WAIT: state_nx = CAPT;
      CAPT: state_nx = SERV;
      SERV: if (eret)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    intr_req = 1'b0;
    mem_req  = 1'b0;
    mem_addr = 32'd0;
    mem_we   = 1'b0;
    if (state == REQ) begin
      intr_req = 1'b1;
    end
    if (state == ADDR) begin
      mem_req  = 1'b1;
      mem_addr = VEC_BASE + {28'd0, cause, 2'b00};
    end
  end

  // cause is frozen at the IDLE->REQ decision so the fetch survives irq/ie dropping.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cause <= 2'd0;
    end else if (state == IDLE && take_irq) begin
      cause <= pick_idx;
    end
  end

  // mem_din is the memory's registered output, stable by CAPT.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vec_pc    <= 32'd0;
      vec_valid <= 1'b0;
    end else begin
      vec_valid <= (state == CAPT);
      if (state == CAPT) begin
        vec_pc <= mem_din;
      end
    end
  end

endmodule

// File: tb/tb_intr_vec_fetch.sv
// Bench for intr_vec_fetch: directed scenarios plus randomized fetches checked against
// a priority/table model. Define IVF_MASK_EN to also exercise the mask register.
module tb_intr_vec_fetch;
  localparam logic [31:0] VEC_BASE = 32'h00000020;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic [3:0]  irq = 4'd0;
  logic        ie = 1'b0;
  logic        intr_ack = 1'b0;
  logic        eret = 1'b0;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_din = 32'd0;
  logic        intr_req, vec_valid, mem_req, mem_we;
  logic [31:0] vec_pc, mem_addr;
  logic [1:0]  cause;
`ifdef IVF_MASK_EN
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = 4'd0;
`endif

  logic [31:0] tbl [4];
  logic [31:0] mem_off;
  logic [3:0]  mask_model = 4'hF;
  int tests = 0;
  int fails = 0;

  bit          r_req, r_drop, r_stable;
  logic [1:0]  r_creq, r_cval;
  logic [31:0] r_agnt, r_await, r_vec;
  int          r_lat, r_vc;

  intr_vec_fetch #(.VEC_BASE(VEC_BASE)) dut (
    .clk(clk), .clrn(clrn), .irq(irq), .ie(ie), .intr_req(intr_req),
    .intr_ack(intr_ack), .eret(eret), .vec_pc(vec_pc), .vec_valid(vec_valid),
    .cause(cause), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_din(mem_din)
`ifdef IVF_MASK_EN
    , .mask_we(mask_we), .mask_wdata(mask_wdata)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data registered on a granted request, held otherwise.
  assign mem_off = mem_addr - VEC_BASE;
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_din <= tbl[mem_off[3:2]];
  end

  function automatic int prio(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic load_default_table();
    tbl[0] = 32'h30; tbl[1] = 32'h3c; tbl[2] = 32'h54; tbl[3] = 32'h68;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clrn = 1'b0; irq = 4'd0; ie = 1'b0; intr_ack = 1'b0; eret = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
  endtask

  // Drives one full interrupt/fetch sequence from IDLE and returns what was observed.
  task automatic run_fetch(input logic [3:0] irqv, input int gnt_dly,
                           output bit req_seen, output logic [1:0] creq, output bit drop,
                           output bit stable, output logic [31:0] agnt, output logic [31:0] wait_addr,
                           output int lat, output int vc, output logic [31:0] vec, output logic [1:0] cval);
    logic [31:0] first;
    req_seen = 0; creq = 0; drop = 0; stable = 0; agnt = 0; wait_addr = 0;
    lat = -1; vc = 0; vec = 0; cval = 0;
    irq = irqv; ie = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (intr_req === 1'b1) begin req_seen = 1; break; end
    end
    if (!req_seen) begin irq = 4'd0; ie = 1'b0; return; end
    creq = cause;
    intr_ack = 1'b1; irq = 4'd0; ie = 1'b0;
    @(negedge clk);
    intr_ack = 1'b0;
    drop = (intr_req === 1'b0);
    stable = 1; first = mem_addr;
    for (int i = 0; i < gnt_dly; i++) begin
      if (mem_req !== 1'b1 || mem_addr !== first) stable = 0;
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    if (mem_req !== 1'b1 || mem_addr !== first) stable = 0;
    agnt = mem_addr;
    @(negedge clk);
    mem_gnt = 1'b0;
    wait_addr = mem_addr;
    for (int i = 0; i < 6; i++) begin
      if (vec_valid === 1'b1) begin
        vc++;
        if (lat < 0) begin lat = i; vec = vec_pc; cval = cause; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    irq = 4'hF; ie = 1'b1;
    #1 clrn = 1'b0;
    #2;
    tests++; if ({intr_req, vec_valid, mem_req, mem_we} !== 4'b0) begin fails++;
      $display("FAIL rst_ctrl: got %b want 0000", {intr_req, vec_valid, mem_req, mem_we}); end
    tests++; if (vec_pc !== 32'd0) begin fails++; $display("FAIL rst_vec_pc: got %h want 0", vec_pc); end
    tests++; if (cause !== 2'd0) begin fails++; $display("FAIL rst_cause: got %0d want 0", cause); end
    tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    @(negedge clk); @(negedge clk);
    tests++; if (intr_req !== 1'b0) begin fails++; $display("FAIL rst_hold_req: got %b want 0", intr_req); end
    clrn = 1'b1;
    #1;
    tests++; if (intr_req !== 1'b0) begin fails++; $display("FAIL rst_release_req: got %b want 0", intr_req); end
    @(negedge clk);
    tests++; if (intr_req !== 1'b1 || cause !== 2'd0) begin fails++;
      $display("FAIL rst_first_req: got req=%b cause=%0d want req=1 cause=0", intr_req, cause); end
    apply_reset();
  endtask

  task automatic test_directed();
    logic [3:0]  iv [3];
    logic [1:0]  ec [3];
    logic [31:0] ea [3];
    logic [31:0] ev [3];
    iv[0] = 4'b0001; ec[0] = 2'd0; ea[0] = 32'h20; ev[0] = 32'h30;
    iv[1] = 4'b1100; ec[1] = 2'd2; ea[1] = 32'h28; ev[1] = 32'h54;
    iv[2] = 4'b1000; ec[2] = 2'd3; ea[2] = 32'h2c; ev[2] = 32'h68;
    load_default_table();
    for (int k = 0; k < 3; k++) begin
      run_fetch(iv[k], 0, r_req, r_creq, r_drop, r_stable, r_agnt, r_await, r_lat, r_vc, r_vec, r_cval);
      tests++; if (!r_req) begin fails++; $display("FAIL dir%0d_req: got 0 want 1", k); end
      tests++; if (!r_drop) begin fails++; $display("FAIL dir%0d_req_drop: got 1 want 0 after ack", k); end
      tests++; if (r_agnt !== ea[k]) begin fails++; $display("FAIL dir%0d_addr: got %h want %h", k, r_agnt, ea[k]); end
      tests++; if (r_vec !== ev[k]) begin fails++; $display("FAIL dir%0d_vec: got %h want %h", k, r_vec, ev[k]); end
      tests++; if (r_cval !== ec[k]) begin fails++; $display("FAIL dir%0d_cause: got %0d want %0d", k, r_cval, ec[k]); end
      tests++; if (r_vc != 1) begin fails++; $display("FAIL dir%0d_valid_len: got %0d want 1", k, r_vc); end
      do_eret();
    end
  endtask

  task automatic test_gnt_stall();
    run_fetch(4'b0010, 3, r_req, r_creq, r_drop, r_stable, r_agnt, r_await, r_lat, r_vc, r_vec, r_cval);
    tests++; if (!r_stable) begin fails++; $display("FAIL stall_stable: got 0 want 1"); end
    tests++; if (r_agnt !== 32'h24) begin fails++; $display("FAIL stall_addr: got %h want 00000024", r_agnt); end
    tests++; if (r_lat != 2) begin fails++; $display("FAIL stall_latency: got %0d want 2", r_lat); end
    tests++; if (r_await !== 32'd0) begin fails++; $display("FAIL stall_addr_wait: got %h want 0", r_await); end
    tests++; if (r_vec !== 32'h3c) begin fails++; $display("FAIL stall_vec: got %h want 0000003c", r_vec); end
    do_eret();
  endtask

  task automatic test_ignore();
    intr_ack = 1'b1; eret = 1'b1;
    @(negedge clk); @(negedge clk);
    intr_ack = 1'b0; eret = 1'b0;
    tests++; if ({intr_req, mem_req} !== 2'b00 || mem_addr !== 32'd0) begin fails++;
      $display("FAIL ign_idle: got req=%b mreq=%b addr=%h want 0", intr_req, mem_req, mem_addr); end
    irq = 4'b0001; ie = 1'b1;
    @(negedge clk);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    tests++; if (intr_req !== 1'b1 || mem_req !== 1'b0) begin fails++;
      $display("FAIL ign_eret_in_req: got req=%b mreq=%b want 1 0", intr_req, mem_req); end
    intr_ack = 1'b1; irq = 4'd0; ie = 1'b0;
    @(negedge clk);
    intr_ack = 1'b0;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL ign_ack_addr: got %b want 1", mem_req); end
    apply_reset();
  endtask

  task automatic test_serv_eret();
    bit bad = 0;
    run_fetch(4'b0100, 1, r_req, r_creq, r_drop, r_stable, r_agnt, r_await, r_lat, r_vc, r_vec, r_cval);
    irq = 4'b0001; ie = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (intr_req !== 1'b0) bad = 1;
    end
    tests++; if (bad) begin fails++; $display("FAIL serv_no_req: got 1 want 0"); end
    do_eret();
    tests++; if (intr_req !== 1'b0) begin fails++; $display("FAIL eret_idle: got %b want 0", intr_req); end
    @(negedge clk);
    tests++; if (intr_req !== 1'b1 || cause !== 2'd0) begin fails++;
      $display("FAIL eret_rereq: got req=%b cause=%0d want 1 0", intr_req, cause); end
    apply_reset();
  endtask

  task automatic test_reset_mid_fetch();
    int vcount = 0;
    bit got = 0;
    irq = 4'b0100; ie = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (intr_req === 1'b1) begin got = 1; break; end
    end
    tests++; if (!got) begin fails++; $display("FAIL midrst_req: got 0 want 1"); end
    intr_ack = 1'b1; irq = 4'd0; ie = 1'b0;
    @(negedge clk);
    intr_ack = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 clrn = 1'b0;
    #1;
    tests++; if ({intr_req, vec_valid, mem_req, mem_we, cause, mem_addr, vec_pc} !== 70'd0) begin fails++;
      $display("FAIL midrst_outputs: got req=%b vld=%b mreq=%b we=%b cause=%0d addr=%h pc=%h want all 0",
               intr_req, vec_valid, mem_req, mem_we, cause, mem_addr, vec_pc); end
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vec_valid === 1'b1) vcount++;
    end
    tests++; if (vcount != 0) begin fails++; $display("FAIL midrst_valid: got %0d strobes want 0", vcount); end
  endtask

  task automatic test_random();
    logic [3:0]  irqv;
    int          dly, ec;
    logic [31:0] ea;
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) tbl[k] = $urandom;
      irqv = 4'($urandom_range(1, 15));
      dly  = $urandom_range(0, 4);
      ec   = prio(irqv & mask_model);
      ea   = VEC_BASE + 32'(4 * ec);
      run_fetch(irqv, dly, r_req, r_creq, r_drop, r_stable, r_agnt, r_await, r_lat, r_vc, r_vec, r_cval);
      tests++; if (!r_req || r_creq !== 2'(ec)) begin fails++;
        $display("FAIL rnd%0d_req: got req=%b cause=%0d want 1 %0d", n, r_req, r_creq, ec); end
      tests++; if (!r_stable || r_agnt !== ea) begin fails++;
        $display("FAIL rnd%0d_addr: got %h stable=%b want %h", n, r_agnt, r_stable, ea); end
      tests++; if (r_lat != 2 || r_vc != 1) begin fails++;
        $display("FAIL rnd%0d_timing: got lat=%0d len=%0d want 2 1", n, r_lat, r_vc); end
      tests++; if (r_vec !== tbl[ec] || r_cval !== 2'(ec)) begin fails++;
        $display("FAIL rnd%0d_vec: got %h/%0d want %h/%0d", n, r_vec, r_cval, tbl[ec], ec); end
      do_eret();
    end
    load_default_table();
  endtask

  task automatic test_ie_gate();
    bit bad = 0;
    irq = 4'hF; ie = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (intr_req !== 1'b0) bad = 1;
    end
    tests++; if (bad) begin fails++; $display("FAIL ie_gate: got req=1 want 0"); end
    ie = 1'b1;
    @(negedge clk);
    tests++; if (intr_req !== 1'b1 || cause !== 2'd0) begin fails++;
      $display("FAIL ie_raise: got req=%b cause=%0d want 1 0", intr_req, cause); end
    apply_reset();
  endtask

`ifdef IVF_MASK_EN
  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b1110;
    @(negedge clk);
    mask_we = 1'b0; mask_model = 4'b1110;
    run_fetch(4'b0011, 0, r_req, r_creq, r_drop, r_stable, r_agnt, r_await, r_lat, r_vc, r_vec, r_cval);
    tests++; if (r_cval !== 2'd1 || r_vec !== 32'h3c) begin fails++;
      $display("FAIL mask_fetch: got cause=%0d pc=%h want 1 0000003c", r_cval, r_vec); end
    do_eret();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

  initial begin
    load_default_table();
    test_reset();
    test_directed();
    test_gnt_stall();
    test_ignore();
    test_serv_eret();
    test_reset_mid_fetch();
    test_random();
    test_ie_gate();
`ifdef IVF_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intr_vec_fetch.md
INTR_VEC_FETCH -- requirements
Module: intr_vec_fetch

Interface
REQ-001 SHALL have parameter: VEC_BASE, 32'h00000020, byte address of the 4-entry vector table in data memory.
REQ-002 SHALL have port: clk  input  1  single system clock; all state on posedge.
REQ-003 SHALL have port: clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: irq  input  4  level interrupt lines; irq[0] highest priority.
REQ-005 SHALL have port: ie  input  1  CPU global interrupt enable.
REQ-006 SHALL have port: intr_req  output  1  interrupt pending, to CPU.
REQ-007 SHALL have port: intr_ack  input  1  CPU accepts the interrupt at an instruction boundary.
REQ-008 SHALL have port: eret  input  1  CPU returned from the handler.
REQ-009 SHALL have port: vec_pc  output  32  handler address fetched from the table.
REQ-010 SHALL have port: vec_valid  output  1  one-cycle strobe; vec_pc valid.
REQ-011 SHALL have port: cause  output  2  index of the serviced line.
REQ-012 SHALL have port: mem_req  output  1  data-memory bus request.
REQ-013 SHALL have port: mem_gnt  input  1  data-memory bus grant.
REQ-014 SHALL have port: mem_addr  output  32  byte address to data memory.
REQ-015 SHALL have port: mem_we  output  1  write enable; constant 0.
REQ-016 SHALL have port: mem_din  input  32  registered read data from data memory.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, ADDR, WAIT, CAPT, SERV.
REQ-018 IDLE->REQ when ie=1 and effective irq!=0; cause latched as the lowest-index asserted line.
REQ-019 REQ: intr_req=1; REQ->ADDR on intr_ack=1; intr_req drops in the cycle after ack.
REQ-020 ADDR: mem_req=1, mem_addr=VEC_BASE+{cause,2'b00}; held stable until mem_gnt=1; ADDR->WAIT on mem_gnt.
REQ-021 WAIT: one cycle for the synchronous memory read latency; mem_req=0; WAIT->CAPT.
REQ-022 CAPT: mem_din registered into vec_pc; vec_valid=1 for exactly the following cycle; CAPT->SERV.
REQ-023 SERV: in service; new interrupts are not requested; SERV->IDLE on eret=1.
REQ-024 Latched cause SHALL be retained if irq or ie deasserts after IDLE->REQ; the sequence completes.
REQ-025 eret outside SERV and intr_ack outside REQ SHALL be ignored.
REQ-026 vec_pc and cause SHALL hold their values until the next capture.
REQ-027 mem_addr SHALL be 0 when not in ADDR; mem_we SHALL be 0 always.
REQ-028 Simultaneous eret and a pending irq in SERV: go to IDLE; the request is raised one cycle later.
REQ-029 Address arithmetic SHALL be 32-bit modulo 2^32; no overflow check.

Reset
REQ-030 clrn=0 SHALL force IDLE immediately, regardless of clk, including mid-fetch.
REQ-031 Reset values: intr_req=0, vec_valid=0, vec_pc=0, cause=0, mem_req=0, mem_addr=0, mem_we=0.
REQ-032 The first request after clrn rises SHALL occur no earlier than the first posedge with clrn=1.

Configuration
REQ-033 Macro IVF_MASK_EN defined: add ports mask_we (input, 1) and mask_wdata (input, 4); 4-bit mask register, reset 4'hF, loaded on posedge when mask_we=1; effective irq = irq & mask.
REQ-034 IVF_MASK_EN undefined: no mask ports; effective irq = irq.

Verification
REQ-035 Table preloaded words 0x20..0x2c = 0x30,0x3c,0x54,0x68; irq=4'b0001, ie=1, ack, gnt=1 -> mem_addr=0x20, vec_pc=0x30, cause=0, vec_valid one cycle.
REQ-036 irq=4'b1100 -> cause=2, mem_addr=0x28, vec_pc=0x54; eret -> IDLE; irq=4'b1000 -> cause=3, vec_pc=0x68.
REQ-037 mem_gnt held 0 for 3 cycles in ADDR -> mem_req=1 and mem_addr=0x24 stable; fetch completes 2 cycles after gnt.
REQ-038 clrn pulsed low during WAIT -> all outputs 0 asynchronously; vec_valid never asserts.
REQ-039 ie=0 with irq=4'hF -> intr_req stays 0; raise ie -> intr_req next cycle with cause=0.
REQ-040 IVF_MASK_EN defined, mask=4'b1110, irq=4'b0011 -> cause=1, vec_pc=0x3c.
